tdc_acq_ctrl: RTL
=================

Name: tdc_acq_ctrl

Overview:
- Acquisition/readout sequencer between the TDC merge stage, the measurement FIFO and the UART transmitter.
- Write mode: pushes each merged TDC measurement into the FIFO.
- Read mode: drains the FIFO word by word and serialises each word MSB-byte-first to the UART under CTS flow control.
- Owns the sticky write/read error flags that drive the board LEDs.

Parameters:
- WORD_W, 32, FIFO/measurement word width; must be a multiple of 8.
- SETTLE_CYC, 4, cycles waited after entering read mode before `fifo_empty` is trusted; covers the 2-slow-clock empty-flag latency.
- CNT_W, 16, width of the stored-word counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start_wr  in  1  level; acquisition enable
- start_rd  in  1  level; readout enable
- rst_read  in  1  synchronous pulse; clears read error, aborts/ends readout
- meas_valid  in  1  one-cycle pulse; merged TDC result available
- meas_data  in  WORD_W  merged TDC result
- fifo_full  in  1  FIFO full flag
- fifo_empty  in  1  FIFO empty flag
- fifo_wr_en  out  1  FIFO write strobe
- fifo_din  out  WORD_W  FIFO write data
- fifo_rd_en  out  1  FIFO read strobe; `fifo_dout` is valid the cycle after
- fifo_dout  in  WORD_W  FIFO read data
- tx_busy  in  1  UART transmitter busy
- cts  in  1  high = host permits sending
- tx_start  out  1  one-cycle pulse; `tx_byte` is valid with it
- tx_byte  out  8  byte to transmit
- led_write_err  out  1  sticky: measurement dropped on full FIFO
- led_read_err  out  1  sticky: readout started on empty FIFO
- words_stored  out  CNT_W  words written minus words read; saturating

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0, including `fifo_din`, `tx_byte` and `words_stored`.
- States: IDLE, ACQ, SETTLE, FETCH, LATCH, SEND, WAIT_TX.
- IDLE:
  - `start_wr`=1 -> ACQ. `start_wr` has priority when both enables are high.
  - else `start_rd`=1 -> SETTLE, loading the settle counter with SETTLE_CYC.
- ACQ:
  - `meas_valid`=1 and `fifo_full`=0 -> next cycle `fifo_wr_en`=1 for exactly one cycle, `fifo_din`=registered `meas_data`, `words_stored`+1.
  - `meas_valid`=1 and `fifo_full`=1 -> no write; `led_write_err` is set and held.
  - `start_wr`=0 -> IDLE. A measurement arriving in that same cycle is still written.
- SETTLE:
  - Counts down to 0, then goes to FETCH.
  - At expiry, if `fifo_empty`=1 and zero words have been read in this readout, set `led_read_err` and go to IDLE.
- FETCH:
  - `fifo_empty`=1 -> IDLE; normal end of readout.
  - else `fifo_rd_en`=1 for one cycle -> LATCH.
- LATCH: capture `fifo_dout` into the shift register; byte index = WORD_W/8-1; `words_stored`-1; -> SEND.
- SEND:
  - Waits for `tx_busy`=0 and `cts`=1.
  - Then pulses `tx_start` for one cycle with `tx_byte` = the top byte of the shift register -> WAIT_TX.
- WAIT_TX:
  - Waits for `tx_busy` to go high, then low; a 16-cycle timeout stands in for a missed busy-rise.
  - Then shifts the register left by 8.
  - More bytes remaining -> SEND; else -> FETCH.
- Mode changes mid-readout:
  - `start_rd` deasserted, or `start_wr` asserted, during readout: the current word completes (all its bytes), then -> IDLE.
  - Words not yet read stay in the FIFO.
- `rst_read`:
  - In any read state, aborts immediately to IDLE; `tx_start` is not pulsed that cycle.
  - Always clears `led_read_err`.
  - Never clears `led_write_err`; only `rst` does.
- `fifo_rd_en` and `fifo_wr_en` are never high in the same cycle.
- `words_stored` saturates at 2^CNT_W-1 and at 0.
- Latency: `meas_valid` to `fifo_wr_en` = 1 cycle. `fifo_rd_en` to first `tx_start` ≥ 2 cycles.

Optional Feature:
- Macro TDC_FRAME_HEADER_EN.
- Defined: each word is preceded by sync byte 8'hA5, sent with the same SEND/WAIT_TX handshake. Frame length = WORD_W/8+1 bytes.
- Undefined: only the WORD_W/8 data bytes are sent; no header logic is synthesised.

Test Plan:
- Acquisition: `rst` pulse; `start_wr`=1; three `meas_valid` pulses with 32'h0000_0011, 32'h0000_0022, 32'h0000_0033 -> three one-cycle `fifo_wr_en` pulses with matching `fifo_din`; `words_stored`=3; both LEDs 0.
- Readout (FIFO model holding 32'h1234_5678; `start_wr`=0, `start_rd`=1; UART model busy 10 cycles per byte; `cts`=1) -> `tx_byte` sequence 8'h12, 8'h34, 8'h56, 8'h78; then `fifo_empty` -> IDLE; `words_stored`=0.
- Full FIFO: `fifo_full`=1 during a `meas_valid` in ACQ -> no `fifo_wr_en`; `led_write_err`=1; stays 1 through `rst_read`; cleared only by `rst`.
- Empty readout: `start_rd`=1 with FIFO empty -> after SETTLE_CYC cycles `led_read_err`=1, no `fifo_rd_en`; a `rst_read` pulse clears it.
- Flow control / abort: `cts`=0 holds SEND with no `tx_start` for 50 cycles; `cts`=1 resumes at the same byte; `rst_read` after byte 2 -> IDLE, no further `tx_start`.
- Priority: `start_wr`=`start_rd`=1 from IDLE -> ACQ; with TDC_FRAME_HEADER_EN defined, readout of 32'hDEAD_BEEF -> A5, DE, AD, BE, EF.

Source files
------------

// File: rtl/tdc_acq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tdc_acq_ctrl
// Brief    : Acquisition/readout sequencer between the TDC merge stage, the
//            measurement FIFO and the UART transmitter. Write mode pushes
//            merged measurements into the FIFO; read mode drains the FIFO
//            and serialises each word MSB byte first under CTS flow control.
//            Owns the sticky write/read error flags driving the board LEDs.
// Options  : `define TDC_FRAME_HEADER_EN -> each word is preceded by the
//            sync byte 8'hA5 using the same send handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tdc_acq_ctrl #(
  parameter int WORD_W     = 32,
  parameter int SETTLE_CYC = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_wr,
  input  logic              start_rd,
  input  logic              rst_read,
  input  logic              meas_valid,
  input  logic [WORD_W-1:0] meas_data,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  output logic              fifo_wr_en,
  output logic [WORD_W-1:0] fifo_din,
  output logic              fifo_rd_en,
  input  logic [WORD_W-1:0] fifo_dout,
  input  logic              tx_busy,
  input  logic              cts,
  output logic              tx_start,
  output logic [7:0]        tx_byte,
  output logic              led_write_err,
  output logic              led_read_err,
  output logic [CNT_W-1:0]  words_stored
);

  localparam int c_nbytes = WORD_W / 8;
  localparam int c_idx_w  = (c_nbytes < 2) ? 1 : $clog2(c_nbytes);
  localparam int c_set_w  = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [c_idx_w-1:0] c_last_idx    = c_idx_w'(c_nbytes - 1);
  localparam logic [c_set_w-1:0] c_settle_load = c_set_w'(SETTLE_CYC);
  localparam logic [CNT_W-1:0]   c_cnt_max     = '1;
  localparam logic [3:0]         c_tmo_last    = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACQ     = 3'd1,
    S_SETTLE  = 3'd2,
    S_FETCH   = 3'd3,
    S_LATCH   = 3'd4,
    S_SEND    = 3'd5,
    S_WAIT_TX = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [c_set_w-1:0]  r_settle_cnt;
  logic                r_words_read;
  logic                r_stop;
  logic [WORD_W-1:0]   r_shreg;
  logic [c_idx_w-1:0]  r_byte_idx;
  logic                r_seen_busy;
  logic [3:0]          r_tmo;
  logic                w_hdr_pend;
  logic                w_read_state;
  logic                w_mode_exit;
  logic                w_settle_done;
  logic                w_tx_done;
  logic                w_wr_hit;
  logic                w_wr_drop;
  logic                w_set_rd_err;

  assign w_read_state  = (r_state inside {S_SETTLE, S_FETCH, S_LATCH, S_SEND, S_WAIT_TX});
  assign w_mode_exit   = !start_rd || start_wr;
  assign w_settle_done = (r_settle_cnt <= c_set_w'(1));
  // busy must rise then fall; the timeout covers a busy pulse we never saw
  assign w_tx_done     = (r_seen_busy && !tx_busy) || (r_tmo == c_tmo_last);
  assign w_wr_hit      = (r_state == S_ACQ) && meas_valid && !fifo_full;
  assign w_wr_drop     = (r_state == S_ACQ) && meas_valid && fifo_full;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode plus the combinational strobes (rd_en, tx_start)
  always_comb begin
    w_next       = r_state;
    fifo_rd_en   = 1'b0;
    tx_start     = 1'b0;
    w_set_rd_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_wr)      w_next = S_ACQ;
        else if (start_rd) w_next = S_SETTLE;
      end
      S_ACQ: begin
        if (!start_wr) w_next = S_IDLE;
      end
      S_SETTLE: begin
        if (rst_read || r_stop || w_mode_exit) begin
          w_next = S_IDLE;
        end else if (w_settle_done) begin
          if (fifo_empty && !r_words_read) begin
            w_set_rd_err = 1'b1;
            w_next       = S_IDLE;
          end else begin
            w_next = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        // word boundary: the only place a pending mode change takes effect
        if (rst_read || r_stop || w_mode_exit || fifo_empty) begin
          w_next = S_IDLE;
        end else begin
          fifo_rd_en = 1'b1;
          w_next     = S_LATCH;
        end
      end
      S_LATCH: begin
        w_next = rst_read ? S_IDLE : S_SEND;
      end
      S_SEND: begin
        if (rst_read) begin
          w_next = S_IDLE;
        end else if (!tx_busy && cts) begin
          tx_start = 1'b1;
          w_next   = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        if (rst_read) begin
          w_next = S_IDLE;
        end else if (w_tx_done) begin
          if (w_hdr_pend)                   w_next = S_SEND;
          else if (r_byte_idx == '0)        w_next = S_FETCH;
          else                              w_next = S_SEND;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // FIFO write path and stored-word counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_wr_en   <= 1'b0;
      fifo_din     <= '0;
      words_stored <= '0;
    end else begin
      fifo_wr_en <= w_wr_hit;
      if (w_wr_hit) fifo_din <= meas_data;
      if (w_wr_hit && (r_state != S_LATCH)) begin
        if (words_stored != c_cnt_max) words_stored <= words_stored + CNT_W'(1);
      end else if (!w_wr_hit && (r_state == S_LATCH)) begin
        if (words_stored != '0) words_stored <= words_stored - CNT_W'(1);
      end
    end
  end

  // Sticky error flags; rst_read clears only the read error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_write_err <= 1'b0;
      led_read_err  <= 1'b0;
    end else begin
      if (w_wr_drop) led_write_err <= 1'b1;
      if (rst_read)          led_read_err <= 1'b0;
      else if (w_set_rd_err) led_read_err <= 1'b1;
    end
  end

  // Readout bookkeeping: settle timer, words-read flag, deferred stop request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_settle_cnt <= '0;
      r_words_read <= 1'b0;
      r_stop       <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && (w_next == S_SETTLE)) r_settle_cnt <= c_settle_load;
      else if ((r_state == S_SETTLE) && (r_settle_cnt != '0))
        r_settle_cnt <= r_settle_cnt - c_set_w'(1);
      if (r_state == S_IDLE)       r_words_read <= 1'b0;
      else if (r_state == S_LATCH) r_words_read <= 1'b1;
      if (r_state == S_IDLE)                 r_stop <= 1'b0;
      else if (w_read_state && w_mode_exit)  r_stop <= 1'b1;
    end
  end

  // Byte serialiser: shift register, byte index and the tx handshake tracker
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg     <= '0;
      r_byte_idx  <= '0;
      r_seen_busy <= 1'b0;
      r_tmo       <= '0;
    end else begin
      if (r_state == S_LATCH) begin
        r_shreg    <= fifo_dout;
        r_byte_idx <= c_last_idx;
      end else if ((r_state == S_WAIT_TX) && w_tx_done && !w_hdr_pend) begin
        r_shreg <= r_shreg << 8;
        if (r_byte_idx != '0) r_byte_idx <= r_byte_idx - c_idx_w'(1);
      end
      if (r_state != S_WAIT_TX) begin
        r_seen_busy <= 1'b0;
        r_tmo       <= '0;
      end else begin
        if (tx_busy) r_seen_busy <= 1'b1;
        if (!r_seen_busy && (r_tmo != c_tmo_last)) r_tmo <= r_tmo + 4'd1;
      end
    end
  end

`ifdef TDC_FRAME_HEADER_EN
  localparam logic [7:0] c_sync_byte = 8'hA5;
  logic r_hdr_pend;

  // Header pending from word capture until the sync byte handshake completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            r_hdr_pend <= 1'b0;
    else if (r_state == S_LATCH)                        r_hdr_pend <= 1'b1;
    else if ((r_state == S_WAIT_TX) && w_tx_done)       r_hdr_pend <= 1'b0;
    else if (r_state == S_IDLE)                         r_hdr_pend <= 1'b0;
  end

  assign w_hdr_pend = r_hdr_pend;
  assign tx_byte    = r_hdr_pend ? c_sync_byte : r_shreg[WORD_W-1 -: 8];
`else
  assign w_hdr_pend = 1'b0;
  assign tx_byte    = r_shreg[WORD_W-1 -: 8];
`endif

endmodule
`default_nettype wire
